// File: rtl/mips_datapath_alu_muldiv_if.sv
// Issue/response bundle between the execute stage and the HI/LO multiply/divide unit.
// The master drives operands and control; the slave returns status and HI/LO.
interface mips_datapath_alu_muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              cancel;
  logic [3:0]        func;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              divz;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, cancel, func, data1, data2,
    input  busy, done, result, result_valid, divz, hi, lo
  );

  modport slave (
    input  start, cancel, func, data1, data2,
    output busy, done, result, result_valid, divz, hi, lo
  );
endinterface

// File: rtl/mips_datapath_alu_muldiv.sv
// Multi-cycle HI/LO unit: pipelined multiplier with accumulate/subtract modes and an
// iterative restoring divider resolving DIV_BITS quotient bits per cycle.
module mips_datapath_alu_muldiv #(
  parameter int DATA_W   = 32,
  parameter int MUL_LAT  = 3,
  parameter int DIV_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  mips_datapath_alu_muldiv_if.slave bus
);

  localparam int W2     = 2 * DATA_W;
  localparam int N_ITER = DATA_W / DIV_BITS;
  localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int DCNT_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    F_MULU  = 4'd0,
    F_MULS  = 4'd1,
    F_DIVU  = 4'd2,
    F_DIVS  = 4'd3,
    F_MADDU = 4'd4,
    F_MADDS = 4'd5,
    F_MSUBU = 4'd6,
    F_MSUBS = 4'd7,
    F_MTHI  = 4'd8,
    F_MTLO  = 4'd9,
    F_MFHI  = 4'd10,
    F_MFLO  = 4'd11
  } func_t;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [W2-1:0] div_step(input logic [DATA_W-1:0] rem,
                                              input logic [DATA_W-1:0] quo,
                                              input logic [DATA_W-1:0] dvs);
    logic [DATA_W:0] sh;
    logic [DATA_W:0] diff;
    sh   = {rem, quo[DATA_W-1]};
    diff = sh - {1'b0, dvs};
    if (diff[DATA_W] == 1'b0) begin
      return {diff[DATA_W-1:0], quo[DATA_W-2:0], 1'b1};
    end else begin
      return {sh[DATA_W-1:0], quo[DATA_W-2:0], 1'b0};
    end
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d, divz_q, divz_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              acc_en_q, acc_en_d, acc_sub_q, acc_sub_d;
  logic [W2-1:0]     prod_q [MUL_LAT];
  logic [W2-1:0]     prod_d [MUL_LAT];
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_raw_q, dvd_raw_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

  func_t             func_s;
  logic              op_signed_s;
  logic              accept_s;
  logic [W2-1:0]     a_ext_s, b_ext_s, prod_in_s, hilo_s, acc_s;
  logic [DATA_W-1:0] a_abs_s, b_abs_s, rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;
  logic [DATA_W-1:0] result_s;

  assign func_s   = func_t'(bus.func);
  assign accept_s = (state_q == S_IDLE) && bus.start && !bus.cancel;

  // Operand conditioning: sign-extension for the multiplier, magnitudes for the divider.
  always_comb begin
    op_signed_s = 1'b0;
    case (func_s)
      F_MULS, F_MADDS, F_MSUBS, F_DIVS: op_signed_s = 1'b1;
      default:                          op_signed_s = 1'b0;
    endcase
    if (op_signed_s) begin
      a_ext_s = {{DATA_W{bus.data1[DATA_W-1]}}, bus.data1};
      b_ext_s = {{DATA_W{bus.data2[DATA_W-1]}}, bus.data2};
    end else begin
      a_ext_s = {{DATA_W{1'b0}}, bus.data1};
      b_ext_s = {{DATA_W{1'b0}}, bus.data2};
    end
    prod_in_s = a_ext_s * b_ext_s;
    if (op_signed_s && bus.data1[DATA_W-1]) begin
      a_abs_s = -bus.data1;
    end else begin
      a_abs_s = bus.data1;
    end
    if (op_signed_s && bus.data2[DATA_W-1]) begin
      b_abs_s = -bus.data2;
    end else begin
      b_abs_s = bus.data2;
    end
  end

  // Divider datapath for one cycle plus the final sign correction.
  always_comb begin
    rem_step_s = rem_q;
    quo_step_s = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      {rem_step_s, quo_step_s} = div_step(rem_step_s, quo_step_s, dvs_q);
    end
    if (neg_quo_q) begin
      quo_fix_s = -quo_q;
    end else begin
      quo_fix_s = quo_q;
    end
    if (neg_rem_q) begin
      rem_fix_s = -rem_q;
    end else begin
      rem_fix_s = rem_q;
    end
  end

  // Accumulator input: HI/LO is taken at write time, not at issue.
  always_comb begin
    hilo_s = {hi_q, lo_q};
    if (!acc_en_q) begin
      acc_s = prod_q[MUL_LAT-1];
    end else if (acc_sub_q) begin
      acc_s = hilo_s - prod_q[MUL_LAT-1];
    end else begin
      acc_s = hilo_s + prod_q[MUL_LAT-1];
    end
  end

  // Next-state and register updates for the control FSM.
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divz_d    = divz_q;
    mcnt_d    = mcnt_q;
    dcnt_d    = dcnt_q;
    acc_en_d  = acc_en_q;
    acc_sub_d = acc_sub_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_raw_d = dvd_raw_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    prod_d[0] = prod_in_s;
    for (int i = 1; i < MUL_LAT; i++) begin
      prod_d[i] = prod_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          divz_d = 1'b0;
          case (func_s)
            F_MULU, F_MULS, F_MADDU, F_MADDS, F_MSUBU, F_MSUBS: begin
              state_d   = S_MUL;
              busy_d    = 1'b1;
              mcnt_d    = MCNT_W'(MUL_LAT - 1);
              acc_en_d  = (func_s != F_MULU) && (func_s != F_MULS);
              acc_sub_d = (func_s == F_MSUBU) || (func_s == F_MSUBS);
            end
            F_DIVU, F_DIVS: begin
              state_d   = S_DIV;
              busy_d    = 1'b1;
              dcnt_d    = DCNT_W'(N_ITER - 1);
              rem_d     = {DATA_W{1'b0}};
              quo_d     = a_abs_s;
              dvs_d     = b_abs_s;
              dvd_raw_d = bus.data1;
              neg_quo_d = op_signed_s && (bus.data1[DATA_W-1] ^ bus.data2[DATA_W-1]);
              neg_rem_d = op_signed_s && bus.data1[DATA_W-1];
              dz_d      = (bus.data2 == {DATA_W{1'b0}});
            end
            F_MTHI:  hi_d = bus.data1;
            F_MTLO:  lo_d = bus.data1;
            default: hi_d = hi_q;
          endcase
        end else begin
          busy_d = 1'b0;
        end
      end
      S_MUL: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (mcnt_q == {MCNT_W{1'b0}}) begin
          {hi_d, lo_d} = acc_s;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
        end else begin
          mcnt_d = mcnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          if (dcnt_q == {DCNT_W{1'b0}}) begin
            state_d = S_FIX;
          end else begin
            dcnt_d = dcnt_q - 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.cancel) begin
          done_d = 1'b0;
        end else if (dz_q) begin
          hi_d   = dvd_raw_q;
          lo_d   = {DATA_W{1'b1}};
          divz_d = 1'b1;
          done_d = 1'b1;
        end else begin
          hi_d   = rem_fix_s;
          lo_d   = quo_fix_s;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= {DATA_W{1'b0}};
      lo_q      <= {DATA_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
      mcnt_q    <= {MCNT_W{1'b0}};
      dcnt_q    <= {DCNT_W{1'b0}};
      acc_en_q  <= 1'b0;
      acc_sub_q <= 1'b0;
      rem_q     <= {DATA_W{1'b0}};
      quo_q     <= {DATA_W{1'b0}};
      dvs_q     <= {DATA_W{1'b0}};
      dvd_raw_q <= {DATA_W{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_q[i] <= {W2{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
      mcnt_q    <= mcnt_d;
      dcnt_q    <= dcnt_d;
      acc_en_q  <= acc_en_d;
      acc_sub_q <= acc_sub_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_raw_q <= dvd_raw_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      for (int i = 0; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  // HI/LO read mux follows func live, independent of what was issued.
  always_comb begin
    case (func_s)
      F_MFHI:  result_s = hi_q;
      F_MFLO:  result_s = lo_q;
      default: result_s = {DATA_W{1'b0}};
    endcase
  end

  assign bus.result       = result_s;
  assign bus.result_valid = ~busy_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.divz         = divz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: doc/mips_datapath_alu_muldiv.md
Name: mips_datapath_alu_muldiv

Overview:
Multi-cycle HI/LO multiply/divide unit. It is the parametrised successor to the single-cycle HI/LO ALU stage and sits beside the main ALU in the execute stage. It adds a pipelined multiplier, an iterative divider with configurable bits-per-cycle, multiply-accumulate/subtract modes, cancel, and a start/busy/done handshake that the hazard unit uses to stall on HI/LO reads.

Parameters:
DATA_W, 32, operand, HI and LO width.
MUL_LAT, 3, multiplier latency in cycles; must be ≥1.
DIV_BITS, 1, quotient bits resolved per divide iteration; 1 or 2; DATA_W % DIV_BITS == 0.

Ports:
ctrl  input  control bundle  Clock field (rising edge), Reset field (asynchronous, active-high).
start  input  1  issue the op in func; sampled only when busy=0.
cancel  input  1  abort the in-flight mul/div; HI/LO unchanged.
func  input  Alu Func type  Mulu/Muls/Divu/Divs/Maddu/Madds/Msubu/Msubs/Mthi/Mtlo/Mfhi/Mflo.
data1  input  DATA_W  rs operand / dividend.
data2  input  DATA_W  rt operand / divisor.
busy  output  1  a mul/div is in flight.
done  output  1  one-cycle pulse after the HI/LO write of a mul/div.
result  output  DATA_W  HI when func=Mfhi, LO when func=Mflo, else 0 (combinational).
result_valid  output  1  =~busy; a HI/LO read is legal.
divz  output  1  sticky; set by a divide by zero, cleared by the next accepted start.
hi  output  DATA_W  HI register.
lo  output  DATA_W  LO register.

Behaviour:
- Reset (async, any time, including mid-op): state=IDLE; hi=lo=0; busy=done=divz=0; pipeline and iteration counters cleared.
- States: IDLE, MUL, DIV, FIX.
- Issue: start=1 with busy=1 is ignored; the hazard unit must stall.
- Mthi/Mtlo with start=1 in IDLE: write hi or lo at the same edge (E0). No busy, no done.
- Mul-class op: start accepted at edge E0 → MUL. busy=1 from E0. HI/LO written at E0+MUL_LAT, then return to IDLE. busy low and done=1 for the cycle after E0+MUL_LAT.
  - Mulu/Muls: {hi,lo} = the 2·DATA_W-bit product, unsigned or signed.
  - Madd*: {hi,lo} = {hi,lo} + product.
  - Msub*: {hi,lo} = {hi,lo} − product.
  - Accumulate arithmetic is modulo 2^(2·DATA_W). {hi,lo} is sampled at E0+MUL_LAT, not at issue.
- Div-class op: at E0, latch |data1| and |data2| (abs for Divs, raw for Divu) and the operand signs → DIV. N = DATA_W/DIV_BITS iteration edges, E1..EN, of restoring division. Counter runs N−1 down to 0. EN → FIX. At E(N+1): sign fix, write hi=remainder and lo=quotient, go to IDLE. done pulses the next cycle.
  - Divs sign rules: quotient negative iff the signs differ; remainder takes the sign of the dividend.
- Divide by zero (data2=0 at issue): the same latency is kept. Result is lo = all ones, hi = data1, and divz is set.
- Divs with MIN/−1: lo = MIN, hi = 0, no flag.
- cancel=1 while busy: return to IDLE at the next edge. No HI/LO write, no done. cancel in IDLE has no effect. cancel and start in the same cycle: start is ignored.
- A new start is accepted in the same cycle that done=1 (busy=0 then).
- func is sampled at issue only. Later changes to func affect only result.

Test Plan:
- Reset mid-divide: Divu issued, reset asserted 10 cycles later → immediately hi=lo=0, busy=0; no done afterward.
- Muls with data1=0xFFFFFFFE (−2), data2=3, MUL_LAT=3 → done at cycle 4; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for exactly 3 cycles.
- Madds after Mthi 0, Mtlo 10, with data1=4, data2=−5 → lo=0xFFFFFFF6, hi=0xFFFFFFFF. Follow with Msubu 1×1 → lo=0xFFFFFFF5, hi=0xFFFFFFFF.
- Divs with data1=−7, data2=2, DIV_BITS=1 → write at E0+33; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Repeat with DIV_BITS=2 → write at E0+17.
- Divu with data2=0, data1=0x1234 → lo=0xFFFFFFFF, hi=0x1234, divz=1. The next accepted Mulu clears divz.
- Cancel Mulu at cycle 2; start held during busy, and start together with cancel → hi/lo unchanged, no done, only starts issued while idle are accepted; Mfhi during busy gives result_valid=0.
